// File: rtl/polymac_pkg.sv
// Shared widths, FSM encoding and rounding constant for the polyphase MAC sequencer.
package polymac_pkg;

  localparam int DATA_W  = 16;
  localparam int COEF_W  = 16;
  localparam int TAPS    = 8;
  localparam int PHASES  = 3;
  localparam int ACC_W   = 40;
  localparam int OUT_W   = 16;
  localparam int SHIFT   = 15;

  localparam int TAP_W   = $clog2(TAPS);
  localparam int CADDR_W = $clog2(PHASES * TAPS) + 1;
  localparam int PROD_W  = DATA_W + COEF_W;

  // Half an output LSB, added before the arithmetic shift (round half up).
  localparam logic signed [ACC_W-1:0] RND_CONST =
    {{(ACC_W-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_ROUND = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;

endpackage

// File: rtl/polyphase_mac_seq_if.sv
// Request, memory fetch and result signals between the sequencer and its neighbours.
interface polyphase_mac_seq_if;
  import polymac_pkg::*;

  logic                      start;
  logic [1:0]                phase;
  logic [TAP_W-1:0]          tap_idx;
  logic                      rd_en;
  logic signed [DATA_W-1:0]  sample_in;
  logic [CADDR_W-1:0]        coef_addr;
  logic signed [COEF_W-1:0]  coef_in;
  logic signed [OUT_W-1:0]   out_data;
  logic                      out_we;
  logic                      busy;
  logic                      sat_flag;

  modport master (
    output start, phase, sample_in, coef_in,
    input  tap_idx, rd_en, coef_addr, out_data, out_we, busy, sat_flag
  );

  modport slave (
    input  start, phase, sample_in, coef_in,
    output tap_idx, rd_en, coef_addr, out_data, out_we, busy, sat_flag
  );

endinterface

// File: rtl/polymac_round_sat.sv
// Registered round/shift/limit of the accumulator, loaded when en is high (1 cycle).
// POLYMAC_SAT_EN selects clamping with a sticky sat_flag; otherwise the result wraps.
module polymac_round_sat
  import polymac_pkg::*;
(
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    sat_flag
);

  logic signed [ACC_W-1:0] rnd;
  logic signed [ACC_W-1:0] shf;
  logic signed [OUT_W-1:0] res;

  assign rnd = acc + RND_CONST;
  assign shf = rnd >>> SHIFT;

`ifdef POLYMAC_SAT_EN
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic [ACC_W-OUT_W:0] hi;
  logic                 clamp;

  // In range only when every bit from the output sign bit upward agrees.
  assign hi = shf[ACC_W-1:OUT_W-1];

  always_comb begin
    clamp = !((&hi) || !(|hi));
    res   = shf[OUT_W-1:0];
    if (clamp) res = shf[ACC_W-1] ? OUT_MIN : OUT_MAX;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)             sat_flag <= 1'b0;
    else if (en && clamp)  sat_flag <= 1'b1;
  end
`else
  logic unused_hi;

  assign unused_hi = ^shf[ACC_W-1:OUT_W];
  assign res       = shf[OUT_W-1:0];
  assign sat_flag  = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)   out_data <= '0;
    else if (en) out_data <= res;
  end

endmodule

// File: rtl/polyphase_mac_seq.sv
// Polyphase FIR MAC sequencer: one start -> TAPS fetches, out_we TAPS+4 cycles later.
// No backpressure; start is ignored while busy. POLYMAC_SAT_EN selects saturating output.
module polyphase_mac_seq
  import polymac_pkg::*;
(
  input  logic                sys_clk,
  input  logic                reset,
  polyphase_mac_seq_if.slave  bus
);

  logic [2:0]              state;
  logic [TAP_W-1:0]        tap_cnt;
  logic                    drain_cnt;
  logic [1:0]              phase_q;
  logic                    phase_ok;

  logic                    d1_vld;
  logic                    d1_first;
  logic                    p_vld;
  logic                    p_first;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc;

  logic signed [OUT_W-1:0] res_data;
  logic                    res_sat;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      tap_cnt   <= '0;
      drain_cnt <= 1'b0;
      phase_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state   <= ST_FETCH;
            tap_cnt <= '0;
            phase_q <= bus.phase;
          end
        end
        ST_FETCH: begin
          tap_cnt <= tap_cnt + 1'b1;
          if (tap_cnt == TAP_W'(TAPS - 1)) begin
            state     <= ST_DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        ST_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= ST_ROUND;
        end
        ST_ROUND: state <= ST_WRITE;
        ST_WRITE: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign phase_ok = (phase_q < 2'(PHASES));

  // TAPS is a power of two, so phase*TAPS+tap is a plain concatenation.
  assign bus.coef_addr = CADDR_W'({phase_q, tap_cnt});
  assign bus.tap_idx   = tap_cnt;
  assign bus.rd_en     = (state == ST_FETCH);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.out_we    = (state == ST_WRITE);

  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  // Memory read data lands one cycle after rd_en, the product one cycle after that.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      d1_vld   <= 1'b0;
      d1_first <= 1'b0;
      p_vld    <= 1'b0;
      p_first  <= 1'b0;
      prod     <= '0;
      acc      <= '0;
    end else begin
      d1_vld   <= bus.rd_en;
      d1_first <= bus.rd_en && (tap_cnt == '0);
      p_vld    <= d1_vld;
      p_first  <= d1_first;
      if (d1_vld)
        prod <= phase_ok ? PROD_W'(bus.sample_in) * PROD_W'(bus.coef_in) : '0;
      if (p_vld)
        acc <= p_first ? prod_ext : acc + prod_ext;
    end
  end

  polymac_round_sat u_round_sat (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .en       (state == ST_ROUND),
    .acc      (acc),
    .out_data (res_data),
    .sat_flag (res_sat)
  );

  assign bus.out_data = res_data;
  assign bus.sat_flag = res_sat;

endmodule

// File: tb/tb_polyphase_mac_seq.sv
// Directed bench for polyphase_mac_seq with sync sample RAM / coef ROM models.
module tb_polyphase_mac_seq;
  import polymac_pkg::*;

  logic sys_clk = 1'b0;
  logic reset;

  always #5 sys_clk = ~sys_clk;

  polyphase_mac_seq_if bus();

  polyphase_mac_seq dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus.slave)
  );

  logic signed [DATA_W-1:0] smem [TAPS];
  logic signed [COEF_W-1:0] crom [64];

  int n_chk  = 0;
  int n_fail = 0;
  int rd_cnt;
  int tap_log  [TAPS];
  int addr_log [TAPS];

  always @(posedge sys_clk) begin
    if (bus.rd_en) begin
      bus.sample_in <= smem[bus.tap_idx];
      bus.coef_in   <= crom[bus.coef_addr];
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill(input int sval, input int cval);
    for (int k = 0; k < TAPS; k++) smem[k] = 16'(sval);
    for (int a = 0; a < 64; a++)   crom[a] = 16'(cval);
  endtask

  // Start sampled at edge 0; iteration c observes cycle c (#1 after edge c-1).
  task automatic run_sample(input logic [1:0] ph, output int we_cyc);
    @(posedge sys_clk); #1 bus.start = 1'b1; bus.phase = ph;
    @(posedge sys_clk); #1 bus.start = 1'b0;
    we_cyc = -1;
    rd_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.rd_en) begin
        if (rd_cnt < TAPS) begin
          tap_log[rd_cnt]  = int'(bus.tap_idx);
          addr_log[rd_cnt] = int'(bus.coef_addr);
        end
        rd_cnt++;
      end
      if (bus.out_we) begin
        we_cyc = c;
        break;
      end
      @(posedge sys_clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int we;
    int we1, we2, busy13, n_we;
    longint d1, d2;

    bus.start     = 1'b0;
    bus.phase     = 2'd0;
    bus.sample_in = '0;
    bus.coef_in   = '0;
    reset         = 1'b1;
    fill(0, 0);
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_out_we",   longint'(bus.out_we),    0);
    check("rst_busy",     longint'(bus.busy),      0);
    check("rst_rd_en",    longint'(bus.rd_en),     0);
    check("rst_out_data", longint'(bus.out_data),  0);
    check("rst_sat_flag", longint'(bus.sat_flag),  0);
    check("rst_tap_idx",  longint'(bus.tap_idx),   0);
    check("rst_coef_adr", longint'(bus.coef_addr), 0);
    reset = 1'b0;

    // 8 * 1000 * 16384 >> 15 = 4000
    fill(1000, 16384);
    run_sample(2'd0, we);
    check("p0_we_cycle", we, 12);
    check("p0_out_data", longint'(bus.out_data), 4000);
    check("p0_rd_cycles", rd_cnt, 8);
    check("p0_sat_flag", longint'(bus.sat_flag), 0);
    @(posedge sys_clk); #1;
    check("p0_busy_after", longint'(bus.busy), 0);
    check("p0_we_after",   longint'(bus.out_we), 0);
    check("p0_hold",       longint'(bus.out_data), 4000);

    // sum 100(k+1)*1024(k+1) = 20889600 -> 637.5 rounds up to 638
    for (int k = 0; k < TAPS; k++) smem[k] = 16'(100 * (k + 1));
    for (int a = 0; a < 64; a++)   crom[a] = (a < 32) ? 16'(1024 * (a - 15)) : 16'(0);
    run_sample(2'd2, we);
    check("p2_we_cycle", we, 12);
    check("p2_rd_cycles", rd_cnt, 8);
    for (int k = 0; k < TAPS; k++) begin
      check($sformatf("p2_tap_idx%0d", k), tap_log[k], k);
      check($sformatf("p2_coef_addr%0d", k), addr_log[k], 16 + k);
    end
    check("p2_out_data", longint'(bus.out_data), 638);

    // Full-scale: +262128 and -262136 before limiting.
    fill(32767, 32767);
    run_sample(2'd0, we);
    check("satp_we_cycle", we, 12);
`ifdef POLYMAC_SAT_EN
    check("satp_out_data", longint'(bus.out_data), 32767);
    check("satp_flag",     longint'(bus.sat_flag), 1);
`else
    check("wrapp_out_data", longint'(bus.out_data), -16);
    check("wrapp_flag",     longint'(bus.sat_flag), 0);
`endif
    fill(-32768, 32767);
    run_sample(2'd0, we);
    check("satn_we_cycle", we, 12);
`ifdef POLYMAC_SAT_EN
    check("satn_out_data", longint'(bus.out_data), -32768);
    check("satn_flag",     longint'(bus.sat_flag), 1);
`else
    check("wrapn_out_data", longint'(bus.out_data), 8);
    check("wrapn_flag",     longint'(bus.sat_flag), 0);
`endif

    // Reset in the middle of a sample.
    fill(1000, 16384);
    @(posedge sys_clk); #1 bus.start = 1'b1; bus.phase = 2'd0;
    @(posedge sys_clk); #1 bus.start = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1 reset = 1'b1;
    @(posedge sys_clk); #1;
    check("mid_rst_busy",  longint'(bus.busy),  0);
    check("mid_rst_rd_en", longint'(bus.rd_en), 0);
    reset = 1'b0;
    n_we = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge sys_clk); #1;
      if (bus.out_we) n_we++;
    end
    check("mid_rst_no_we", n_we, 0);
    run_sample(2'd0, we);
    check("post_rst_we_cycle", we, 12);
    check("post_rst_out_data", longint'(bus.out_data), 4000);

    // Starts at cycles 3 and 12 ignored; start at 13 (phase 3) accepted.
    @(posedge sys_clk); #1 bus.start = 1'b1; bus.phase = 2'd0;
    @(posedge sys_clk); #1 bus.start = 1'b0;
    we1 = -1; we2 = -1; d1 = -1; d2 = -1; busy13 = -1;
    for (int c = 1; c <= 40; c++) begin
      if (bus.out_we) begin
        if (we1 < 0) begin
          we1 = c; d1 = longint'(bus.out_data);
        end else begin
          we2 = c; d2 = longint'(bus.out_data);
        end
      end
      if (c == 13) busy13 = int'(bus.busy);
      if (we2 >= 0) break;
      case (c)
        3:       bus.start = 1'b1;
        12:      bus.start = 1'b1;
        13:      begin bus.start = 1'b1; bus.phase = 2'd3; end
        default: bus.start = 1'b0;
      endcase
      @(posedge sys_clk); #1;
    end
    bus.start = 1'b0;
    check("ign_first_we",   we1, 12);
    check("ign_first_data", d1, 4000);
    check("ign_busy_c13",   busy13, 0);
    check("ign_second_we",  we2, 25);
    check("ph3_out_data",   d2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
